// File: rtl/ysyx_22050612_wbu_if.sv
// ysyx_22050612_wbu_if
// Bundles every non-clock/reset signal of the writeback unit.
//   issue_*      : decode -> wbu. Claims a destination register (issue_ready is the grant).
//   alu_*        : ALU result handshake (valid/ready, rd, data).
//   lsu_*        : load result handshake (valid/ready, rd, data).
//   rs1/rs2      : decode operand indices; rs1_busy/rs2_busy report pending writebacks.
//   wen/waddr/wdata : registered register-file write port.
//   retire_cnt   : running count of accepted results.
// Optional YSYX_22050612_WB_FWD_EN adds rs1_fwd/rs2_fwd/fwd_data for bypassing the write port.
// Modports: master = the surrounding pipeline (or a bench), slave = the writeback unit.
interface ysyx_22050612_wbu_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  issue_ready;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           retire_cnt;

`ifdef YSYX_22050612_WB_FWD_EN
  logic                  rs1_fwd;
  logic                  rs2_fwd;
  logic [DATA_WIDTH-1:0] fwd_data;

  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    input  issue_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
           wen, waddr, wdata, retire_cnt, rs1_fwd, rs2_fwd, fwd_data
  );

  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    output issue_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
           wen, waddr, wdata, retire_cnt, rs1_fwd, rs2_fwd, fwd_data
  );
`else
  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    input  issue_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
           wen, waddr, wdata, retire_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    output issue_ready, alu_ready, lsu_ready, rs1_busy, rs2_busy,
           wen, waddr, wdata, retire_cnt
  );
`endif
endinterface

// File: rtl/ysyx_22050612_wbu.sv
// ysyx_22050612_wbu
// Writeback unit: arbitrates ALU and LSU results (LSU has fixed priority), registers the chosen
// result for one cycle onto the register-file write port, tracks per-register pending writes in
// a scoreboard so decode can stall, and counts retired results.
// Ports:
//   clk  : clock, all state on posedge.
//   rst  : synchronous active-high reset.
//   bus  : ysyx_22050612_wbu_if.slave carrying issue, ALU/LSU handshakes, operand busy queries,
//          the write port and retire_cnt.
// Build option: define YSYX_22050612_WB_FWD_EN to bypass the write port to decode
// (rs1_fwd/rs2_fwd/fwd_data); operands being written this cycle then read as not busy.
module ysyx_22050612_wbu #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22050612_wbu_if.slave       bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  // Scoreboard: bit i set while a result for register i is outstanding.
  logic [NumRegs-1:0]    busy_q, busy_d;

  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           retire_q, retire_d;

  logic                  lsu_ready, alu_ready, issue_ready;
  logic                  lsu_fire, alu_fire, any_fire, issue_fire;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  rs1_raw_busy, rs2_raw_busy;
  logic                  rs1_hit, rs2_hit;

  // Handshake readies never look at their own valid; ALU yields to any pending load.
  always_comb begin
    lsu_ready   = !rst;
    alu_ready   = !rst && !bus.lsu_valid;
    issue_ready = !rst && ((bus.issue_rd == '0) || !busy_q[bus.issue_rd]);
  end

  always_comb begin
    lsu_fire   = bus.lsu_valid && lsu_ready;
    alu_fire   = bus.alu_valid && alu_ready;
    any_fire   = lsu_fire || alu_fire;
    issue_fire = bus.issue_valid && issue_ready;
  end

  always_comb begin
    sel_rd   = bus.alu_rd;
    sel_data = bus.alu_data;
    if (lsu_fire) begin
      sel_rd   = bus.lsu_rd;
      sel_data = bus.lsu_data;
    end
  end

  // Write port: address/data hold when idle so waveforms show the last write.
  always_comb begin
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    retire_d = retire_q;
    if (any_fire) begin
      wen_d    = (sel_rd != '0);
      waddr_d  = sel_rd;
      wdata_d  = sel_data;
      retire_d = retire_q + 32'd1;
    end
  end

  // Clear lands on the same edge as the register-file write. A set on the same index cannot
  // coincide because issue_ready is low while that index is busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (issue_fire && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      retire_q <= '0;
    end else begin
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      retire_q <= retire_d;
    end
  end

  // Operand queries. Register 0 is hard-wired and never reports busy.
  always_comb begin
    rs1_raw_busy = (bus.rs1 != '0) && busy_q[bus.rs1];
    rs2_raw_busy = (bus.rs2 != '0) && busy_q[bus.rs2];
    rs1_hit      = wen_q && (waddr_q == bus.rs1) && (bus.rs1 != '0);
    rs2_hit      = wen_q && (waddr_q == bus.rs2) && (bus.rs2 != '0);
  end

`ifdef YSYX_22050612_WB_FWD_EN
  // Value on the write port is already final, so a matching operand can take it this cycle.
  assign bus.rs1_fwd  = rs1_hit;
  assign bus.rs2_fwd  = rs2_hit;
  assign bus.fwd_data = wdata_q;
  assign bus.rs1_busy = rs1_raw_busy && !rs1_hit;
  assign bus.rs2_busy = rs2_raw_busy && !rs2_hit;
`else
  // Without bypass the operand stays busy until the register file has been written.
  logic unused_hit;
  assign unused_hit   = rs1_hit ^ rs2_hit;
  assign bus.rs1_busy = rs1_raw_busy;
  assign bus.rs2_busy = rs2_raw_busy;
`endif

  assign bus.lsu_ready   = lsu_ready;
  assign bus.alu_ready   = alu_ready;
  assign bus.issue_ready = issue_ready;
  assign bus.wen         = wen_q;
  assign bus.waddr       = waddr_q;
  assign bus.wdata       = wdata_q;
  assign bus.retire_cnt  = retire_q;

endmodule
